// File: rtl/power_switch_sequencer_if.sv
// Request/status bundle between a retention domain's save/restore controller and its switch sequencer.
// Defining PSW_ACK_CHECK_EN adds the per-segment acknowledge input and the sticky timeout flag.
interface power_switch_sequencer_if #(
  parameter int unsigned NUM_SEGMENTS = 4
);
  logic                    power_switch_en;
  logic                    wake_req;
  logic [NUM_SEGMENTS-1:0] seg_en;
  logic                    pwr_good;
  logic                    power_up_done;
  logic                    ramp_busy;
  logic [2:0]              seq_state;
`ifdef PSW_ACK_CHECK_EN
  logic [NUM_SEGMENTS-1:0] psw_ack;
  logic                    ack_timeout;

  modport master (
    output power_switch_en, wake_req, psw_ack,
    input  seg_en, pwr_good, power_up_done, ramp_busy, seq_state, ack_timeout
  );
  modport slave (
    input  power_switch_en, wake_req, psw_ack,
    output seg_en, pwr_good, power_up_done, ramp_busy, seq_state, ack_timeout
  );
`else
  modport master (
    output power_switch_en, wake_req,
    input  seg_en, pwr_good, power_up_done, ramp_busy, seq_state
  );
  modport slave (
    input  power_switch_en, wake_req,
    output seg_en, pwr_good, power_up_done, ramp_busy, seq_state
  );
`endif
endinterface

// File: rtl/power_switch_sequencer.sv
// Staggered header power-switch sequencer: ramps segments on/off one at a time, settles, reports pwr_good.
// Optional macro PSW_ACK_CHECK_EN gates every step on the per-segment switch acknowledge.
module power_switch_sequencer #(
  parameter int unsigned NUM_SEGMENTS   = 4,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned SETTLE_CYCLES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  power_switch_sequencer_if.slave bus
);
  localparam int unsigned CW   = $clog2(NUM_SEGMENTS + 1);
  localparam int unsigned TMAX = (STAGGER_CYCLES > SETTLE_CYCLES) ? STAGGER_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] STAG_TC   = TW'(STAGGER_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_TC = TW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] FULL      = CW'(NUM_SEGMENTS);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    ST_ON        = 3'd0,
    ST_RAMP_DOWN = 3'd1,
    ST_OFF       = 3'd2,
    ST_RAMP_UP   = 3'd3,
    ST_SETTLE    = 3'd4
  } state_t;

  state_t                  state;
  logic [CW-1:0]           seg_count;
  logic [NUM_SEGMENTS-1:0] seg_en;
  logic [TW-1:0]           timer;
  logic                    pwr_good;
  logic                    power_up_done;
  logic                    ramp_busy;
  logic                    wake_fired;
  logic                    adv_ok;

`ifdef PSW_ACK_CHECK_EN
  localparam int unsigned ACK_TIMEOUT = 1024;

  logic [15:0] ack_wait;
  logic        ack_timeout;
  logic        stall;

  // Step permission: newest segment acknowledged on, just-dropped segment acknowledged off, all on to settle.
  always_comb begin
    adv_ok = 1'b1;
    case (state)
      ST_RAMP_UP:   adv_ok = |(bus.psw_ack & (NUM_SEGMENTS'(1) << (seg_count - ONE)));
      ST_RAMP_DOWN: adv_ok = ~|(bus.psw_ack & (NUM_SEGMENTS'(1) << seg_count));
      ST_SETTLE:    adv_ok = &bus.psw_ack;
      default:      adv_ok = 1'b1;
    endcase
  end

  assign stall = !adv_ok && ((state == ST_SETTLE) ||
                 (((state == ST_RAMP_UP) || (state == ST_RAMP_DOWN)) && (timer == STAG_TC)));

  // The sequence keeps waiting after a timeout; the flag only reports it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_wait    <= '0;
      ack_timeout <= 1'b0;
    end else if (stall) begin
      if (ack_wait != 16'hFFFF) ack_wait <= ack_wait + 16'd1;
      if (ack_wait == 16'(ACK_TIMEOUT - 1)) ack_timeout <= 1'b1;
    end else begin
      ack_wait <= '0;
    end
  end

  assign bus.ack_timeout = ack_timeout;
`else
  assign adv_ok = 1'b1;
`endif

  // seg_en shadows seg_count as a thermometer code: shift right to drop, shift in a one to add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_ON;
      seg_count     <= FULL;
      seg_en        <= '1;
      pwr_good      <= 1'b1;
      power_up_done <= 1'b0;
      ramp_busy     <= 1'b0;
      timer         <= '0;
      wake_fired    <= 1'b0;
    end else begin
      power_up_done <= 1'b0;
      case (state)
        ST_ON: begin
          if (!bus.power_switch_en) begin
            state     <= ST_RAMP_DOWN;
            seg_count <= seg_count - ONE;
            seg_en    <= seg_en >> 1;
            pwr_good  <= 1'b0;
            ramp_busy <= 1'b1;
            timer     <= '0;
          end
        end
        ST_RAMP_DOWN: begin
          if (bus.power_switch_en) begin
            seg_count <= seg_count + ONE;
            seg_en    <= {seg_en[NUM_SEGMENTS-2:0], 1'b1};
            timer     <= '0;
            state     <= (seg_count == FULL - ONE) ? ST_SETTLE : ST_RAMP_UP;
          end else if (timer == STAG_TC) begin
            if (adv_ok) begin
              seg_count <= seg_count - ONE;
              seg_en    <= seg_en >> 1;
              timer     <= '0;
              if (seg_count == ONE) begin
                state     <= ST_OFF;
                ramp_busy <= 1'b0;
              end
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_OFF: begin
          if (bus.wake_req && !wake_fired) begin
            power_up_done <= 1'b1;
            wake_fired    <= 1'b1;
          end
          if (bus.power_switch_en) begin
            state      <= ST_RAMP_UP;
            seg_count  <= ONE;
            seg_en     <= NUM_SEGMENTS'(1);
            ramp_busy  <= 1'b1;
            timer      <= '0;
            wake_fired <= 1'b0;
          end
        end
        ST_RAMP_UP: begin
          if (!bus.power_switch_en) begin
            seg_count <= seg_count - ONE;
            seg_en    <= seg_en >> 1;
            timer     <= '0;
            if (seg_count == ONE) begin
              state     <= ST_OFF;
              ramp_busy <= 1'b0;
            end else begin
              state <= ST_RAMP_DOWN;
            end
          end else if (timer == STAG_TC) begin
            if (adv_ok) begin
              seg_count <= seg_count + ONE;
              seg_en    <= {seg_en[NUM_SEGMENTS-2:0], 1'b1};
              timer     <= '0;
              if (seg_count == FULL - ONE) state <= ST_SETTLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_SETTLE: begin
          if (!bus.power_switch_en) begin
            state     <= ST_RAMP_DOWN;
            seg_count <= seg_count - ONE;
            seg_en    <= seg_en >> 1;
            timer     <= '0;
          end else if (adv_ok) begin
            if (timer == SETTLE_TC) begin
              state     <= ST_ON;
              pwr_good  <= 1'b1;
              ramp_busy <= 1'b0;
              timer     <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        default: begin
          state      <= ST_ON;
          seg_count  <= FULL;
          seg_en     <= '1;
          pwr_good   <= 1'b1;
          ramp_busy  <= 1'b0;
          timer      <= '0;
          wake_fired <= 1'b0;
        end
      endcase
    end
  end

  assign bus.seg_en        = seg_en;
  assign bus.pwr_good      = pwr_good;
  assign bus.power_up_done = power_up_done;
  assign bus.ramp_busy     = ramp_busy;
  assign bus.seq_state     = state;

endmodule

// File: tb/tb_power_switch_sequencer.sv
// Bench for power_switch_sequencer: directed vector table, reset/wake corner sequences,
// and random request/wake traffic compared against a level-and-direction reference model.
module tb_power_switch_sequencer;
  localparam int unsigned N  = 4;
  localparam int unsigned S  = 8;
  localparam int unsigned SE = 16;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic wake;

  always #5 clk = ~clk;

  power_switch_sequencer_if #(.NUM_SEGMENTS(N)) bus ();

  assign bus.power_switch_en = en;
  assign bus.wake_req        = wake;
`ifdef PSW_ACK_CHECK_EN
  assign bus.psw_ack = '1;
`endif

  power_switch_sequencer #(
    .NUM_SEGMENTS  (N),
    .STAGGER_CYCLES(S),
    .SETTLE_CYCLES (SE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: how many segments are on, which way the domain is heading,
  // cycles spent on the current step, and whether the settle window is done.
  int m_lvl;
  bit m_up;
  int m_age;
  bit m_good;
  bit m_used;
  bit m_done;

  task automatic model_reset();
    m_lvl  = N;
    m_up   = 1'b1;
    m_age  = 0;
    m_good = 1'b1;
    m_used = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit w);
    bit was_off;
    was_off = (m_lvl == 0);
    m_done  = was_off && w && !m_used;
    if (e) begin
      if (m_lvl == N) begin
        if (!m_good) begin
          if (m_age == SE - 1) m_good = 1'b1;
          else m_age++;
        end
      end else if (!m_up) begin
        m_up = 1'b1; m_lvl++; m_age = 0;
      end else if (m_age == S - 1) begin
        m_lvl++; m_age = 0;
      end else begin
        m_age++;
      end
    end else begin
      if (m_lvl == 0) begin
        m_age = 0;
      end else if (m_up) begin
        m_up = 1'b0; m_good = 1'b0; m_lvl--; m_age = 0;
      end else if (m_age == S - 1) begin
        m_lvl--; m_age = 0;
      end else begin
        m_age++;
      end
    end
    if (m_lvl != 0) m_used = 1'b0;
    else if (m_done) m_used = 1'b1;
  endtask

  function automatic int m_state();
    if (m_good) return 0;
    if (m_lvl == 0) return 2;
    if (m_lvl == N) return 4;
    return m_up ? 3 : 1;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_seg_en"},   32'(bus.seg_en),        32'((1 << m_lvl) - 1));
    check({tag, "_pwr_good"}, 32'(bus.pwr_good),      32'(m_good));
    check({tag, "_done"},     32'(bus.power_up_done), 32'(m_done));
    check({tag, "_busy"},     32'(bus.ramp_busy),     32'(!m_good && (m_lvl != 0)));
    check({tag, "_state"},    32'(bus.seq_state),     32'(m_state()));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_step(en, wake);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    en   = 1'b1;
    wake = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    int       ncyc;
    bit       en;
    bit       wake;
    logic [3:0] seg;
    bit       good;
    bit       done;
    bit       busy;
    int       st;
  } vec_t;

  function automatic vec_t mk(int n, bit e, bit w, logic [3:0] s, bit g, bit d, bit b, int st);
    vec_t v;
    v.ncyc = n; v.en = e; v.wake = w; v.seg = s;
    v.good = g; v.done = d; v.busy = b; v.st = st;
    return v;
  endfunction

  vec_t vec[$];
  int   pulses;
  int   hold;

  initial begin
    // cycles, en, wake -> seg_en, pwr_good, power_up_done, ramp_busy, seq_state after the last cycle
    vec.push_back(mk(50, 1, 0, 4'hF, 1, 0, 0, 0));  // powered and idle
    vec.push_back(mk( 1, 0, 0, 4'h7, 0, 0, 1, 1));  // drop: top segment off at once
    vec.push_back(mk( 8, 0, 0, 4'h3, 0, 0, 1, 1));
    vec.push_back(mk( 8, 0, 0, 4'h1, 0, 0, 1, 1));
    vec.push_back(mk( 8, 0, 0, 4'h0, 0, 0, 0, 2));  // fully off
    vec.push_back(mk( 1, 0, 1, 4'h0, 0, 1, 0, 2));  // first wake sample pulses
    vec.push_back(mk( 9, 0, 1, 4'h0, 0, 0, 0, 2));  // held wake: no second pulse
    vec.push_back(mk( 1, 1, 0, 4'h1, 0, 0, 1, 3));  // raise: segment 0 at once
    vec.push_back(mk(24, 1, 0, 4'hF, 0, 0, 1, 4));  // all on, settling
    vec.push_back(mk(16, 1, 0, 4'hF, 1, 0, 0, 0));  // pwr_good at T+41
    vec.push_back(mk(25, 0, 0, 4'h0, 0, 0, 0, 2));
    vec.push_back(mk( 1, 1, 0, 4'h1, 0, 0, 1, 3));
    vec.push_back(mk( 9, 1, 0, 4'h3, 0, 0, 1, 3));  // T+10
    vec.push_back(mk( 1, 0, 0, 4'h1, 0, 0, 1, 1));  // abort: T+11
    vec.push_back(mk( 8, 0, 0, 4'h0, 0, 0, 0, 2));  // T+19
    vec.push_back(mk( 5, 0, 0, 4'h0, 0, 0, 0, 2));  // no pulse without new wake
    vec.push_back(mk( 1, 1, 1, 4'h1, 0, 1, 1, 3));  // wake and raise together
    vec.push_back(mk(40, 1, 1, 4'hF, 1, 0, 0, 0));  // wake ignored outside off
    vec.push_back(mk( 1, 0, 1, 4'h7, 0, 0, 1, 1));
    vec.push_back(mk( 1, 1, 0, 4'hF, 0, 0, 1, 4));  // reverse back to full: settle
    vec.push_back(mk(16, 1, 0, 4'hF, 1, 0, 0, 0));
    vec.push_back(mk(25, 0, 0, 4'h0, 0, 0, 0, 2));
    vec.push_back(mk( 1, 1, 0, 4'h1, 0, 0, 1, 3));
    vec.push_back(mk( 1, 0, 0, 4'h0, 0, 0, 0, 2));  // abort on first segment: straight to off
    vec.push_back(mk( 1, 0, 1, 4'h0, 0, 1, 0, 2));  // wake re-armed after leaving off

    rst  = 1'b1;
    en   = 1'b1;
    wake = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vec[i]) begin
      en   = vec[i].en;
      wake = vec[i].wake;
      for (int c = 0; c < vec[i].ncyc; c++) step("tbl_model");
      check($sformatf("vec%0d_seg_en", i),   32'(bus.seg_en),        32'(vec[i].seg));
      check($sformatf("vec%0d_pwr_good", i), 32'(bus.pwr_good),      32'(vec[i].good));
      check($sformatf("vec%0d_done", i),     32'(bus.power_up_done), 32'(vec[i].done));
      check($sformatf("vec%0d_busy", i),     32'(bus.ramp_busy),     32'(vec[i].busy));
      check($sformatf("vec%0d_state", i),    32'(bus.seq_state),     32'(vec[i].st));
    end

    // Asynchronous reset in the middle of a ramp-down with two segments left on.
    wake = 1'b0;
    en   = 1'b1;
    for (int c = 0; c < 41; c++) step("hs_up");
    check("hs_up_pwr_good", 32'(bus.pwr_good), 32'd1);
    en = 1'b0;
    for (int c = 0; c < 9; c++) step("hs_down");
    check("hs_down_seg_en", 32'(bus.seg_en), 32'h3);
    do_reset("hs_rst");
    check("hs_rst_seg_en",   32'(bus.seg_en),        32'hF);
    check("hs_rst_pwr_good", 32'(bus.pwr_good),      32'd1);
    check("hs_rst_state",    32'(bus.seq_state),     32'd0);
    check("hs_rst_done",     32'(bus.power_up_done), 32'd0);

    // Wake raised only while ramping down must not produce a pulse once off.
    pulses = 0;
    en   = 1'b0;
    wake = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step("hs_wake");
      if (bus.power_up_done === 1'b1) pulses++;
    end
    wake = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step("hs_wake");
      if (bus.power_up_done === 1'b1) pulses++;
    end
    check("hs_wake_pulses", 32'(pulses), 32'd0);
    check("hs_wake_state",  32'(bus.seq_state), 32'd2);

    // Random request dwell times straddle the stagger and settle windows.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        en   = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 60);
      end
      hold--;
      wake = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) do_reset("rand_rst");
      else step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1);
  end

endmodule
